// File: rtl/vmul_pkg.sv
// Shared types and helpers for the 32-bit vector multiply pass sequencer.
package vmul_pkg;

  typedef enum logic [1:0] {
    PR8  = 2'b00,
    PR16 = 2'b01,
    PR32 = 2'b10
  } precision_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  localparam logic [2:0] PASSES_PR8  = 3'd2;
  localparam logic [2:0] PASSES_PR16 = 3'd2;
  localparam logic [2:0] PASSES_PR32 = 3'd4;

  // The reserved encoding 2'b11 behaves as full 32-bit precision.
  function automatic precision_e norm_precision(input logic [1:0] p);
    case (p)
      2'b00:   return PR8;
      2'b01:   return PR16;
      default: return PR32;
    endcase
  endfunction

  function automatic logic [2:0] pass_count(input precision_e p);
    case (p)
      PR8:     return PASSES_PR8;
      PR16:    return PASSES_PR16;
      default: return PASSES_PR32;
    endcase
  endfunction

endpackage

// File: rtl/vmul_pass_accum.sv
// 64-bit partial-product accumulator: lane insert for 8/16-bit passes,
// shift-and-add for the four 32-bit passes.
module vmul_pass_accum
  import vmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [1:0]  pass_idx_i,
  input  precision_e  precision_i,
  input  logic [31:0] mul_result_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [63:0] prod_ext;

  assign prod_ext = {32'h0, mul_result_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (capture_i) begin
      if (precision_i == PR32) begin
        case (pass_idx_i)
          2'd0:    acc_d = acc_q + prod_ext;
          2'd1,
          2'd2:    acc_d = acc_q + (prod_ext << 16);
          default: acc_d = acc_q + (prod_ext << 32);
        endcase
      end else if (pass_idx_i == 2'd0) begin
        acc_d[31:0] = mul_result_i;
      end else begin
        acc_d[63:32] = mul_result_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/vmul32_pass_sequencer.sv
// Drives 2 or 4 pipelined 16x16 passes through a shared multiplier and
// accumulates a 64-bit lane-packed result. MUL_SEQ_PERF_CNT_EN adds busy_cycles.
module vmul32_pass_sequencer
  import vmul_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      operand_a,
  input  logic [31:0]      operand_b,
  input  logic [1:0]       precision,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      result,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic [1:0]       mul_precision,
  input  logic [31:0]      mul_result
`ifdef MUL_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] busy_cycles
`endif
);

  seq_state_e             state_q;
  precision_e             prec_q;
  precision_e             prec_in;
  logic [31:0]            a_q;
  logic [31:0]            b_q;
  logic [2:0]             n_q;
  logic [2:0]             iss_q;
  logic [2:0]             col_q;
  logic                   drv_q;
  logic [MUL_LATENCY-1:0] cap_pipe_q;
  logic [15:0]            mul_a_q;
  logic [15:0]            mul_b_q;
  logic [1:0]             mul_prec_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [15:0]            pass_a;
  logic [15:0]            pass_b;
  logic                   accept;
  logic                   capture;

  assign prec_in = norm_precision(precision);
  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  // A pass issued MUL_LATENCY cycles ago has its product on mul_result now.
  assign capture = (state_q == RUN) && cap_pipe_q[MUL_LATENCY-1];

  // Operand halves for the next pass from the latched request.
  always_comb begin
    pass_a = a_q[15:0];
    pass_b = b_q[15:0];
    if (prec_q == PR32) begin
      case (iss_q[1:0])
        2'd0:    begin pass_a = a_q[15:0];  pass_b = b_q[15:0];  end
        2'd1:    begin pass_a = a_q[15:0];  pass_b = b_q[31:16]; end
        2'd2:    begin pass_a = a_q[31:16]; pass_b = b_q[15:0];  end
        default: begin pass_a = a_q[31:16]; pass_b = b_q[31:16]; end
      endcase
    end else if (iss_q != 3'd0) begin
      pass_a = a_q[31:16];
      pass_b = b_q[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prec_q      <= PR8;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      iss_q       <= '0;
      col_q       <= '0;
      drv_q       <= 1'b0;
      cap_pipe_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_prec_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cap_pipe_q[0] <= drv_q;
      for (int i = 1; i < MUL_LATENCY; i++) cap_pipe_q[i] <= cap_pipe_q[i-1];
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Pass 0 is always AL x BL, so it is issued straight from the inputs.
            state_q    <= RUN;
            prec_q     <= prec_in;
            a_q        <= operand_a;
            b_q        <= operand_b;
            n_q        <= pass_count(prec_in);
            iss_q      <= 3'd1;
            col_q      <= 3'd0;
            drv_q      <= 1'b1;
            mul_a_q    <= operand_a[15:0];
            mul_b_q    <= operand_b[15:0];
            mul_prec_q <= (prec_in == PR8) ? 2'b00 : 2'b01;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (iss_q < n_q) begin
            mul_a_q    <= pass_a;
            mul_b_q    <= pass_b;
            mul_prec_q <= (prec_q == PR8) ? 2'b00 : 2'b01;
            iss_q      <= iss_q + 3'd1;
            drv_q      <= 1'b1;
          end else begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_prec_q <= '0;
            drv_q      <= 1'b0;
          end
          if (capture) begin
            col_q <= col_q + 3'd1;
            if (col_q == n_q - 3'd1) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  vmul_pass_accum u_accum (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (accept),
    .capture_i    (capture),
    .pass_idx_i   (col_q[1:0]),
    .precision_i  (prec_q),
    .mul_result_i (mul_result),
    .acc_o        (result)
  );

`ifdef MUL_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (state_q != IDLE && busy_q != {CNT_W{1'b1}}) begin
      busy_q <= busy_q + 1'b1;
    end
  end

  assign busy_cycles = busy_q;
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign mul_precision = mul_prec_q;

endmodule

// File: tb/tb_vmul32_pass_sequencer.sv
// Directed bench for vmul32_pass_sequencer with a behavioural 1-cycle
// multiplier_16bit model; busy_cycles checked when MUL_SEQ_PERF_CNT_EN is defined.
module tb_vmul32_pass_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [1:0]  precision = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [1:0]  mul_precision;
  logic [31:0] mul_result = '0;
`ifdef MUL_SEQ_PERF_CNT_EN
  logic [31:0] busy_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vmul32_pass_sequencer #(.MUL_LATENCY(1), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .precision     (precision),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_precision (mul_precision),
    .mul_result    (mul_result)
`ifdef MUL_SEQ_PERF_CNT_EN
    ,
    .busy_cycles   (busy_cycles)
`endif
  );

  // Reference multiplier_16bit: one register stage, two 8x8 lanes or one 16x16.
  always @(posedge clk) begin
    logic [15:0] lo8, hi8;
    lo8 = {8'h0, mul_a[7:0]} * {8'h0, mul_b[7:0]};
    hi8 = {8'h0, mul_a[15:8]} * {8'h0, mul_b[15:8]};
    if (mul_precision == 2'b00) mul_result <= {hi8, lo8};
    else                        mul_result <= {16'h0, mul_a} * {16'h0, mul_b};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request accepted this cycle, out_ready held high; out_valid only in cycle lat.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] p, input int lat, input logic [63:0] exp);
    check({tag, " in_ready@0"}, 64'(in_ready), 64'd1);
    operand_a = a;
    operand_b = b;
    precision = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    precision = 2'($urandom_range(0, 3));
    for (int c = 1; c <= lat; c++) begin
      check($sformatf("%s in_ready@%0d", tag, c), 64'(in_ready), 64'd0);
      check($sformatf("%s out_valid@%0d", tag, c), 64'(out_valid), 64'(c == lat));
      if (c == lat) check({tag, " result"}, result, exp);
      tick();
    end
    check({tag, " out_valid after"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", result, 64'd0);
    check("rst mul_a", 64'(mul_a), 64'd0);
    check("rst mul_b", 64'(mul_b), 64'd0);
    check("rst mul_precision", 64'(mul_precision), 64'd0);
    rst = 1'b1;
    tick();

    // Full-scale 32-bit product, latency 6
    do_op("pr32 max", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 6, 64'hFFFFFFFE00000001);

    // 16-bit lanes: 2*4, 3*5
    operand_a = 32'h00030002;
    operand_b = 32'h00050004;
    precision = 2'b01;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pr16 mul_precision@1", 64'(mul_precision), 64'd1);
    check("pr16 mul_a@1", 64'(mul_a), 64'h0002);
    check("pr16 mul_b@1", 64'(mul_b), 64'h0004);
    tick(); tick(); tick();
    check("pr16 out_valid@4", 64'(out_valid), 64'd1);
    check("pr16 result", result, 64'h0000000F00000008);
    tick();

    // 8-bit lanes: 1*5, 2*6, 3*7, 4*8
    operand_a = 32'h04030201;
    operand_b = 32'h08070605;
    precision = 2'b00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pr8 mul_precision@1", 64'(mul_precision), 64'd0);
    check("pr8 mul_a@1", 64'(mul_a), 64'h0201);
    check("pr8 mul_b@1", 64'(mul_b), 64'h0605);
    tick();
    check("pr8 mul_precision@2", 64'(mul_precision), 64'd0);
    check("pr8 mul_a@2", 64'(mul_a), 64'h0403);
    check("pr8 mul_b@2", 64'(mul_b), 64'h0807);
    tick();
    check("pr8 mul_a idle@3", 64'(mul_a), 64'd0);
    tick();
    check("pr8 out_valid@4", 64'(out_valid), 64'd1);
    check("pr8 result", result, 64'h00200015000C0005);
    tick();

    // Backpressure: (2<<16|3)*(4<<16|5), out_ready low cycles 6-8
    operand_a = 32'h00020003;
    operand_b = 32'h00040005;
    precision = 2'b10;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check("bp out_valid@6", 64'(out_valid), 64'd1);
    check("bp result@6", result, 64'h000000080016000F);
    operand_a = 32'h00030002;
    operand_b = 32'h00050004;
    precision = 2'b01;
    in_valid  = 1'b1;
    for (int c = 7; c <= 9; c++) begin
      tick();
      if (c == 9) out_ready = 1'b1;
      check($sformatf("bp out_valid@%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp in_ready@%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("bp result@%0d", c), result, 64'h000000080016000F);
      check($sformatf("bp mul_a@%0d", c), 64'(mul_a), 64'd0);
    end
    tick();
    check("bp in_ready@10", 64'(in_ready), 64'd1);
    check("bp out_valid@10", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp2 in_ready@11", 64'(in_ready), 64'd0);
    tick(); tick();
    check("bp2 out_valid@13", 64'(out_valid), 64'd0);
    tick();
    check("bp2 out_valid@14", 64'(out_valid), 64'd1);
    check("bp2 result@14", result, 64'h0000000F00000008);
    tick();

    // Asynchronous reset in cycle 2 of a 32-bit op
    operand_a = 32'hFFFFFFFF;
    operand_b = 32'hFFFFFFFF;
    precision = 2'b10;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort result", result, 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort mul_a", 64'(mul_a), 64'd0);
`ifdef MUL_SEQ_PERF_CNT_EN
    check("abort busy", 64'(busy_cycles), 64'd0);
`endif
    #1 rst = 1'b1;
    tick();
    check("abort out_valid later", 64'(out_valid), 64'd0);

    // Back-to-back ops after the abort; 2'b11 behaves as 32-bit
    do_op("post abort", 32'h00000002, 32'h00000003, 2'b10, 6, 64'h6);
`ifdef MUL_SEQ_PERF_CNT_EN
    check("busy after pr32", 64'(busy_cycles), 64'd6);
`endif
    do_op("b2b pr16", 32'h00030002, 32'h00050004, 2'b01, 4, 64'h0000000F00000008);
`ifdef MUL_SEQ_PERF_CNT_EN
    check("busy after pr16", 64'(busy_cycles), 64'd10);
`endif
    do_op("b2b pr11", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 6, 64'hFFFFFFFE00000001);
`ifdef MUL_SEQ_PERF_CNT_EN
    check("busy after pr11", 64'(busy_cycles), 64'd16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmul32_pass_sequencer.md
Name: vmul32_pass_sequencer

Overview:
Sequences one shared multiplier_16bit instance to execute full 32-bit vector multiply operands at all three precisions (8/16/32-bit lanes).
- Accepts one 32x32 request per valid/ready handshake.
- Issues 2 or 4 pipelined 16x16 passes and accumulates the partial products into a 64-bit result.
- Presents that result on a valid/ready output.
- Sits between the two's-complement pre-stage (operands arrive as unsigned magnitudes) and the sign-fix/select post-stage.

Parameters:
- MUL_LATENCY, 1, cycles from multiplier operand drive to mul_result valid; must match multiplier_16bit's register stage.
- CNT_W, 32, width of the optional busy-cycle counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  sequencer can accept a request
- operand_a  input  32  unsigned operand A (lanes per precision)
- operand_b  input  32  unsigned operand B
- precision  input  2  00=8-bit lanes, 01=16-bit lanes, 10=32-bit; 11 treated as 10
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  64  full product(s), lane-packed
- mul_a  output  16  operand A to multiplier_16bit
- mul_b  output  16  operand B to multiplier_16bit
- mul_precision  output  2  precision to multiplier_16bit: 00 for 8-bit passes, 01 otherwise
- mul_result  input  32  multiplier_16bit output
- busy_cycles  output  CNT_W  only when MUL_SEQ_PERF_CNT_EN is defined

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All registers clear; in_ready=1, out_valid=0, result=0.
  - mul_a, mul_b and mul_precision are driven to 0.
  - A reset mid-operation aborts the operation with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands and precision, clear the accumulator and both counters, then go to RUN.
  - RUN: in_ready=0. Issue counter iss drives pass iss each cycle while iss<N. Collect counter col captures mul_result when an issued pass is MUL_LATENCY old. After capturing pass N-1, go to DONE.
  - DONE: out_valid=1 and result is held stable until out_ready. On out_ready go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Pass count: N=2 for precision 00 and 01; N=4 for precision 10.
- Pass schedule (A=a[31:16]:a[15:0] = AH:AL, same for B):
  - Precision 00: pass0 drives AL,BL; mul_result gives {a1*b1, a0*b0} into result[31:0]. pass1 drives AH,BH into result[63:32].
  - Precision 01: pass0 drives AL*BL into result[31:0]; pass1 drives AH*BH into result[63:32].
  - Precision 10: passes in order AL*BL, AL*BH, AH*BL, AH*BH. Accumulation is acc += p0 + (p1<<16) + (p2<<16) + (p3<<32), 64-bit unsigned, no overflow possible.
- Timing (cycle 0 = accept cycle):
  - Pass k is driven in cycle 1+k and captured at the end of cycle 1+k+MUL_LATENCY.
  - out_valid rises in cycle N+1+MUL_LATENCY: 4 cycles for 00/01, 6 cycles for 10 (MUL_LATENCY=1).
- mul_a, mul_b and mul_precision are 0 when no pass is being issued.
- Input operands and precision are ignored outside the IDLE accept cycle.

Optional Feature:
- Macro: MUL_SEQ_PERF_CNT_EN.
- Defined: busy_cycles port exists. It increments every cycle the FSM is not IDLE, saturates at all-ones, and resets to 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package vmul_pkg:
  - precision_e enum: PR8=2'b00, PR16=2'b01, PR32=2'b10.
  - seq_state_e: IDLE, RUN, DONE.
  - Constants PASSES_PR8=2, PASSES_PR16=2, PASSES_PR32=4.
  - Function pass_count(precision).
- Sub-module vmul_pass_accum holds the 64-bit accumulator and the shift/add or lane-insert logic.
  - Inputs: pass index, precision, mul_result, capture strobe, clear.

Test Plan:
- Precision 10, a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1: result=0xFFFFFFFE00000001, out_valid exactly in cycle 6, in_ready low cycles 1-6.
- Precision 01, a=0x00030002, b=0x00050004: result=0x0000000F00000008 in cycle 4.
- Precision 00, a=0x04030201, b=0x08070605: result=0x00200015000C0005 in cycle 4; mul_precision=00 during passes.
- Precision 10 with out_ready held low 3 cycles after out_valid: result and out_valid stable, in_ready=0, new in_valid ignored. Accept occurs only after the out_ready handshake.
- rst pulsed low in cycle 2 of a precision-10 op: out_valid=0, result=0, in_ready=1 immediately. A subsequent op (a=2, b=3, precision 10) returns 0x6.
- Back-to-back ops with MUL_SEQ_PERF_CNT_EN defined: busy_cycles increases by 4 per 01 op and 6 per 10 op (out_ready=1). Build with the macro undefined compiles and passes the other tests.
